// File: rtl/impl_chk_pkg.sv
// Shared types and helpers for the delayed-implication checker.
package impl_chk_pkg;

    localparam int MAX_DELAY = 15;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_e;

    function automatic int unsigned popcount(input logic [MAX_DELAY-1:0] vec);
        int unsigned n;
        n = 0;
        for (int i = 0; i < MAX_DELAY; i++) begin
            n = n + {31'b0, vec[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/impl_delay_checker.sv
// Monitors "a implies b exactly DELAY clocks later" on live signals and
// reports registered pass/fail pulses, saturating counts and first-fail time.
//
// state | meaning
// RUN   | new antecedents create obligations
// HALT  | no new obligations; outstanding ones still drain and are judged
module impl_delay_checker
    import impl_chk_pkg::*;
#(
    parameter int DELAY        = 2,
    parameter int CNT_W        = 16,
    parameter int STOP_ON_FAIL = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic                       clr,
    input  logic                       a,
    input  logic                       b,
    output logic                       pass_pulse,
    output logic                       fail_pulse,
    output logic                       fail_sticky,
    output logic [CNT_W-1:0]           pass_cnt,
    output logic [CNT_W-1:0]           fail_cnt,
    output logic [$clog2(DELAY+1)-1:0] pending,
    output logic [CNT_W-1:0]           cycle_cnt,
    output logic [CNT_W-1:0]           first_fail_time,
    output logic                       halted
);

    localparam int PEND_W = $clog2(DELAY + 1);

    if (DELAY < 1 || DELAY > MAX_DELAY) begin : g_bad_delay
        $error("impl_delay_checker: DELAY must be in 1..%0d", MAX_DELAY);
    end

    state_e           state_q, state_d;
    logic [DELAY-1:0] pend_q, pend_d;
    logic             pass_pulse_q, fail_pulse_q;
    logic             fail_sticky_q, fail_sticky_d;
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0] first_fail_q, first_fail_d;

    logic eval_due, pass_ev, fail_ev, capture;

    // clr wins over both a same-edge verdict and a same-edge antecedent
    assign eval_due = pend_q[DELAY-1];
    assign pass_ev  = eval_due &  b & ~clr;
    assign fail_ev  = eval_due & ~b & ~clr;
    assign capture  = en & a & (state_q == RUN) & ~clr;

    always_comb begin
        pend_d    = pend_q << 1;
        pend_d[0] = capture;
        if (clr) begin
            pend_d = '0;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:  if (fail_ev && (STOP_ON_FAIL != 0)) state_d = HALT;
            HALT: state_d = HALT;
        endcase
        if (clr) begin
            state_d = RUN;
        end
    end

    always_comb begin
        fail_sticky_d = fail_sticky_q | fail_ev;
        first_fail_d  = first_fail_q;
        cycle_cnt_d   = cycle_cnt_q + CNT_W'(1);
        if (fail_ev && !fail_sticky_q) begin
            first_fail_d = cycle_cnt_q;
        end
        if (clr) begin
            fail_sticky_d = 1'b0;
            first_fail_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RUN;
            pend_q        <= '0;
            pass_pulse_q  <= 1'b0;
            fail_pulse_q  <= 1'b0;
            fail_sticky_q <= 1'b0;
            first_fail_q  <= '0;
            cycle_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            pend_q        <= pend_d;
            pass_pulse_q  <= pass_ev;
            fail_pulse_q  <= fail_ev;
            fail_sticky_q <= fail_sticky_d;
            first_fail_q  <= first_fail_d;
            cycle_cnt_q   <= cycle_cnt_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_pass_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (pass_ev),
        .clr   (clr),
        .count (pass_cnt)
    );

    sat_counter #(.W(CNT_W)) u_fail_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (fail_ev),
        .clr   (clr),
        .count (fail_cnt)
    );

    assign pending         = PEND_W'(popcount(MAX_DELAY'(pend_q)));
    assign pass_pulse      = pass_pulse_q;
    assign fail_pulse      = fail_pulse_q;
    assign fail_sticky     = fail_sticky_q;
    assign cycle_cnt       = cycle_cnt_q;
    assign first_fail_time = first_fail_q;
    assign halted          = (state_q == HALT);

endmodule

// File: tb/tb_impl_delay_checker.sv
// Bench for impl_delay_checker: three configurations share one stimulus stream
// and are checked every cycle against an edge-history model.
module tb_impl_delay_checker;

    localparam int NI = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0, clr = 1'b0, a = 1'b0, b = 1'b0;

    logic        o_pp [NI];
    logic        o_fp [NI];
    logic        o_st [NI];
    logic        o_hl [NI];
    logic [15:0] o_pc [NI];
    logic [15:0] o_fc [NI];
    logic [15:0] o_cc [NI];
    logic [15:0] o_ff [NI];
    logic [3:0]  o_pd [NI];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic int dly(input int g);  return (g == 1) ? 1 : 2;  endfunction
    function automatic int stp(input int g);  return (g == 1) ? 1 : 0;  endfunction
    function automatic int cwid(input int g); return (g == 2) ? 4 : 16; endfunction

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int D  = (g == 1) ? 1 : 2;
        localparam int S  = (g == 1) ? 1 : 0;
        localparam int CW = (g == 2) ? 4 : 16;
        localparam int PW = $clog2(D + 1);
        logic          pp, fp, st, hl;
        logic [CW-1:0] pc, fc, cc, ff;
        logic [PW-1:0] pd;

        impl_delay_checker #(.DELAY(D), .CNT_W(CW), .STOP_ON_FAIL(S)) u_dut (
            .clk             (clk),
            .rst_n           (rst_n),
            .en              (en),
            .clr             (clr),
            .a               (a),
            .b               (b),
            .pass_pulse      (pp),
            .fail_pulse      (fp),
            .fail_sticky     (st),
            .pass_cnt        (pc),
            .fail_cnt        (fc),
            .pending         (pd),
            .cycle_cnt       (cc),
            .first_fail_time (ff),
            .halted          (hl)
        );

        assign o_pp[g] = pp;
        assign o_fp[g] = fp;
        assign o_st[g] = st;
        assign o_hl[g] = hl;
        assign o_pc[g] = 16'(pc);
        assign o_fc[g] = 16'(fc);
        assign o_cc[g] = 16'(cc);
        assign o_ff[g] = 16'(ff);
        assign o_pd[g] = 4'(pd);
    end

    // Model: acc[g][e%64] records whether the antecedent at edge e was accepted;
    // the verdict at edge e looks back DELAY edges into that history.
    bit acc [NI][64];
    int e_idx;
    int x_pp[NI], x_fp[NI], x_st[NI], x_hl[NI], x_pc[NI], x_fc[NI];
    int x_ff[NI], x_cc[NI], x_pd[NI];

    always @(posedge clk or negedge rst_n) begin
        int d, mx;
        bit due;
        if (!rst_n) begin
            e_idx = 0;
            for (int g = 0; g < NI; g++) begin
                x_pp[g] = 0; x_fp[g] = 0; x_st[g] = 0; x_hl[g] = 0;
                x_pc[g] = 0; x_fc[g] = 0; x_ff[g] = 0; x_cc[g] = 0; x_pd[g] = 0;
                for (int k = 0; k < 64; k++) acc[g][k] = 1'b0;
            end
        end else begin
            for (int g = 0; g < NI; g++) begin
                d   = dly(g);
                mx  = (1 << cwid(g)) - 1;
                due = acc[g][(e_idx + 64 - d) % 64];
                if (clr) begin
                    x_pp[g] = 0; x_fp[g] = 0; x_st[g] = 0; x_hl[g] = 0;
                    x_pc[g] = 0; x_fc[g] = 0; x_ff[g] = 0;
                    for (int k = 0; k < 64; k++) acc[g][k] = 1'b0;
                end else begin
                    x_pp[g] = (due && b) ? 1 : 0;
                    x_fp[g] = (due && !b) ? 1 : 0;
                    if (x_pp[g] == 1 && x_pc[g] < mx) x_pc[g] = x_pc[g] + 1;
                    if (x_fp[g] == 1 && x_fc[g] < mx) x_fc[g] = x_fc[g] + 1;
                    if (x_fp[g] == 1 && x_st[g] == 0) begin
                        x_ff[g] = x_cc[g];
                        x_st[g] = 1;
                    end
                    acc[g][e_idx % 64] = en && a && (x_hl[g] == 0);
                    if (x_fp[g] == 1 && stp(g) == 1) x_hl[g] = 1;
                end
                x_cc[g] = (x_cc[g] + 1) & mx;
                x_pd[g] = 0;
                for (int k = 0; k < d; k++) begin
                    if (acc[g][(e_idx + 64 - k) % 64]) x_pd[g] = x_pd[g] + 1;
                end
            end
            e_idx = e_idx + 1;
        end
    end

    task automatic chk(input string nm, input int g, input logic [31:0] act, input int exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s inst%0d got %0d expected %0d at %0t", nm, g, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        for (int g = 0; g < NI; g++) begin
            chk("pass_pulse",      g, 32'(o_pp[g]), x_pp[g]);
            chk("fail_pulse",      g, 32'(o_fp[g]), x_fp[g]);
            chk("fail_sticky",     g, 32'(o_st[g]), x_st[g]);
            chk("halted",          g, 32'(o_hl[g]), x_hl[g]);
            chk("pass_cnt",        g, 32'(o_pc[g]), x_pc[g]);
            chk("fail_cnt",        g, 32'(o_fc[g]), x_fc[g]);
            chk("cycle_cnt",       g, 32'(o_cc[g]), x_cc[g]);
            chk("first_fail_time", g, 32'(o_ff[g]), x_ff[g]);
            chk("pending",         g, 32'(o_pd[g]), x_pd[g]);
        end
    end

    task automatic drive(input bit ia, input bit ib, input bit ien, input bit iclr);
        a = ia; b = ib; en = ien; clr = iclr;
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_pass_cnt", 0, 32'(o_pc[0]), 0);
        chk("rst_pending",  0, 32'(o_pd[0]), 0);
        chk("rst_halted",   1, 32'(o_hl[1]), 0);

        // edges 0-3: two obligations, both judged with b=0
        drive(1, 1, 1, 0);
        drive(1, 1, 1, 0);
        drive(0, 0, 1, 0);
        chk("t1_fail_pulse_e2", 0, 32'(o_fp[0]), 1);
        chk("t1_first_fail",    0, 32'(o_ff[0]), 2);
        chk("t1_sticky",        0, 32'(o_st[0]), 1);
        drive(0, 0, 1, 0);
        chk("t1_fail_pulse_e3", 0, 32'(o_fp[0]), 1);
        chk("t1_fail_cnt",      0, 32'(o_fc[0]), 2);
        chk("t1_first_hold",    0, 32'(o_ff[0]), 2);
        chk("model_fail_cnt",   0, 32'(x_fc[0]), 2);
        chk("model_first_fail", 0, 32'(x_ff[0]), 2);
        drive(0, 0, 1, 1);                               // edge 4 clr
        chk("clr_halted",   1, 32'(o_hl[1]), 0);
        chk("clr_fail_cnt", 0, 32'(o_fc[0]), 0);

        // edges 5-8: single obligation passes two edges later
        drive(1, 0, 1, 0);
        chk("t2_pending_e5", 0, 32'(o_pd[0]), 1);
        drive(0, 0, 1, 0);
        chk("t2_pending_e6", 0, 32'(o_pd[0]), 1);
        chk("t2_no_pass_e6", 0, 32'(o_pp[0]), 0);
        drive(0, 1, 1, 0);
        chk("t2_pass_pulse", 0, 32'(o_pp[0]), 1);
        chk("t2_pending_e7", 0, 32'(o_pd[0]), 0);
        chk("t2_pass_cnt",   0, 32'(o_pc[0]), 1);
        drive(0, 0, 1, 0);
        chk("t2_pulse_gone", 0, 32'(o_pp[0]), 0);
        drive(0, 0, 1, 1);                               // edge 9 clr

        // edges 10-16: back-to-back antecedents
        drive(1, 0, 1, 0);
        drive(1, 0, 1, 0);
        chk("t3_pending_peak", 0, 32'(o_pd[0]), 2);
        drive(1, 1, 1, 0);
        drive(1, 1, 1, 0);
        drive(1, 1, 1, 0);
        drive(0, 1, 1, 0);
        drive(0, 1, 1, 0);
        chk("t3_pass_cnt",   0, 32'(o_pc[0]), 5);
        chk("t3_fail_cnt",   0, 32'(o_fc[0]), 0);
        chk("model_pass5",   0, 32'(x_pc[0]), 5);
        drive(0, 0, 1, 1);                               // edge 17 clr

        // edges 18-24: stop-on-fail with DELAY=1 (inst1)
        drive(1, 1, 1, 0);
        drive(1, 1, 1, 0);
        drive(1, 1, 1, 0);
        drive(1, 0, 1, 0);
        chk("t4_fail_pulse", 1, 32'(o_fp[1]), 1);
        chk("t4_halted",     1, 32'(o_hl[1]), 1);
        chk("t4_pass_e21",   1, 32'(o_pc[1]), 2);
        drive(1, 1, 1, 0);
        chk("t4_drain_pass", 1, 32'(o_pp[1]), 1);
        chk("t4_pass_e22",   1, 32'(o_pc[1]), 3);
        chk("t4_pending",    1, 32'(o_pd[1]), 0);
        drive(1, 1, 1, 0);
        drive(1, 1, 1, 0);
        chk("t4_pass_hold",  1, 32'(o_pc[1]), 3);
        chk("t4_no_pulse",   1, 32'(o_pp[1]), 0);
        chk("model_halted",  1, 32'(x_hl[1]), 1);
        drive(0, 0, 1, 1);                               // edge 25 clr
        chk("t4_unhalt",     1, 32'(o_hl[1]), 0);

        // edges 26-28: clr discards an outstanding obligation
        drive(1, 0, 1, 0);
        drive(0, 0, 1, 1);
        chk("t5_pending",   0, 32'(o_pd[0]), 0);
        chk("t5_pass_cnt",  0, 32'(o_pc[0]), 0);
        chk("t5_cycle_cnt", 0, 32'(o_cc[0]), 28);
        drive(0, 1, 1, 0);
        chk("t5_no_pass",   0, 32'(o_pp[0]), 0);
        chk("t5_no_fail",   0, 32'(o_fp[0]), 0);
        chk("t5_cycle_e28", 0, 32'(o_cc[0]), 29);

        // edges 29-50: 20 failing obligations, 4-bit counters saturate
        for (int i = 0; i < 20; i++) drive(1, 0, 1, 0);
        drive(0, 0, 1, 0);
        drive(0, 0, 1, 0);
        chk("t6_sat_fail_cnt", 2, 32'(o_fc[2]), 15);
        chk("t6_wide_fail",    0, 32'(o_fc[0]), 20);
        chk("t6_cycle_wrap",   2, 32'(o_cc[2]), 3);
        chk("model_sat",       2, 32'(x_fc[2]), 15);

        // reset mid-obligation
        drive(1, 0, 1, 0);
        drive(1, 0, 1, 0);
        chk("t6_pending_pre", 0, 32'(o_pd[0]), 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_pending", 0, 32'(o_pd[0]), 0);
        chk("rst_async_failcnt", 0, 32'(o_fc[0]), 0);
        chk("rst_async_sticky",  0, 32'(o_st[0]), 0);
        chk("rst_async_cycle",   0, 32'(o_cc[0]), 0);
        chk("rst_async_first",   0, 32'(o_ff[0]), 0);
        chk("rst_async_satcnt",  2, 32'(o_fc[2]), 0);
        a = 1'b0; b = 1'b1;
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        drive(0, 1, 1, 0);
        drive(0, 1, 1, 0);
        chk("rst_no_pass", 0, 32'(o_pp[0]), 0);
        chk("rst_pass_0",  0, 32'(o_pc[0]), 0);
        drive(0, 0, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/impl_delay_checker.md
Name: impl_delay_checker

Overview:
Synthesizable hardware monitor that evaluates the non-overlapped implication "a implies b exactly DELAY clocks later" on live signals. It is the same rule our SVA benches assert on `a |=> ##1 b` (DELAY=2), but this version is built in RTL.
It sits directly downstream of the stimulus/DUT signals those benches drive and consumes the same a/b pair. It exposes pass/fail pulses, saturating counters and a first-failure timestamp, so results are visible in silicon/FPGA and in waveforms without a simulator assertion engine.

Parameters:
DELAY, 2, clocks from antecedent sample to consequent sample; legal range 1..15; DELAY=0 (overlapped) is an elaboration error.
CNT_W, 16, width of pass/fail/cycle counters and timestamp.
STOP_ON_FAIL, 0, 1 = stop creating new obligations after first failure.

Ports:
clk  input  1  clock, all sampling on rising edge
rst_n  input  1  asynchronous active-low reset
en  input  1  1 = new antecedents accepted
clr  input  1  synchronous clear of all state except cycle_cnt
a  input  1  antecedent
b  input  1  consequent
pass_pulse  output  1  one-cycle pulse: obligation met
fail_pulse  output  1  one-cycle pulse: obligation violated
fail_sticky  output  1  set on first failure, held until clr/reset
pass_cnt  output  CNT_W  saturating count of passes
fail_cnt  output  CNT_W  saturating count of failures
pending  output  $clog2(DELAY+1)  number of outstanding obligations
cycle_cnt  output  CNT_W  free-running edge counter, wraps
first_fail_time  output  CNT_W  cycle_cnt value at evaluation edge of first failure
halted  output  1  1 when FSM is in HALT

Behaviour:
- Reset (rst_n=0, async) forces all outputs, counters, obligation register and FSM to 0/RUN immediately.
- Obligation shift register pend[DELAY-1:0], updated at each edge:
  - pend[0] <= en & a & (state==RUN);
  - pend[i] <= pend[i-1].
- Evaluation: at any edge where pend[DELAY-1]=1, the b sampled at that same edge decides the result.
  - b=1 means pass; b=0 means fail.
  - Antecedent sampled at edge t is therefore judged at edge t+DELAY.
- Pulses are registered: high for exactly the one cycle following the evaluation edge, and low otherwise.
  - pass_pulse and fail_pulse are never both 1.
- Overlapping antecedents (a high on consecutive edges) each create an independent obligation, so each is judged separately.
- pending = popcount(pend), combinational from registers.
- Counters:
  - pass_cnt/fail_cnt increment by 1 on the edge their pulse is registered, and saturate at all-ones.
  - cycle_cnt increments every edge, wraps to 0, and is not affected by clr.
- first_fail_time: loaded with the current cycle_cnt at the first fail evaluation while fail_sticky=0. It holds its value afterwards.
- FSM states:
  - RUN: accepts antecedents.
  - HALT: accepts no new antecedents; pending obligations still drain and are evaluated.
  - RUN -> HALT on a fail evaluation when STOP_ON_FAIL=1.
  - HALT -> RUN only on clr or reset.
  - With STOP_ON_FAIL=0 the FSM never leaves RUN.
- en=0: no new obligations; outstanding obligations still evaluated.
- clr=1 at an edge:
  - clears pend, pulses, pass_cnt, fail_cnt, fail_sticky, first_fail_time and FSM to RUN;
  - has priority over a same-edge antecedent (not captured) and a same-edge evaluation (discarded, no count).
- Reset asserted mid-obligation discards all pending obligations with no pulse.

Decomposition:
- Package impl_chk_pkg holds:
  - the state_e enum (RUN, HALT);
  - a popcount function for pending;
  - a localparam for the max legal DELAY.
- One sub-module, sat_counter: parameterised width, inputs inc and clr, saturating output. It is instantiated twice (pass, fail).

Test Plan:
1. DELAY=2; a=1,b=1 on edges 0-1, then a=0,b=0 on edges 2-3 -> fail_pulse after edges 2 and 3; fail_cnt=2; first_fail_time=2; fail_sticky=1.
2. DELAY=2; a=1 at edge 4 only; b=1 at edge 6 -> pass_pulse one cycle after edge 6; pending=1 after edges 4 and 5, and 0 after edge 6.
3. DELAY=2; a=1 on edges 0-4 continuously; b=1 from edge 2 onward -> pending peaks at 2; pass_cnt=5; no fail_pulse.
4. STOP_ON_FAIL=1, DELAY=1; a=1 every edge; b=0 at edge 3 only:
   - fail after edge 3, then halted=1;
   - the obligation from edge 3 still passes at edge 4;
   - no obligations created from edge 4 on;
   - pass_cnt stays constant after edge 4.
5. DELAY=2; a=1 at edge 10, clr=1 at edge 11 -> pending=0 after edge 11; no pulse at edge 12; counters 0; cycle_cnt unaffected.
6. CNT_W=4; 20 consecutive failing obligations -> fail_cnt saturates at 15. Separately, rst_n pulsed low mid-sequence -> all outputs 0 asynchronously, and pending=0.
